// File: rtl/cover_pkg.sv
// Shared constants and helpers for the toggle-coverage drain.
// Imported by the drain top and its picker.
package cover_pkg;

  localparam int COVER_IDX_W = 64;
  localparam int COVER_TOTAL = 38253;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int idx_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cover_toggle_drain_if.sv
// Cover-index stream handshake between the drain
// and the coverage uplink.
interface cover_toggle_drain_if;
  import cover_pkg::*;

  logic                   out_valid;
  logic                   out_ready;
  logic [COVER_IDX_W-1:0] out_index;

  modport master (
    output out_valid,
    output out_index,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    output out_ready
  );

endinterface

// File: rtl/cover_lsb_pick.sv
// Combinational lowest-set-bit picker with a
// one-hot clear vector for the chosen bit.
module cover_lsb_pick
  import cover_pkg::*;
#(
  parameter int WIDTH = 39
) (
  input  logic [WIDTH-1:0]          vec,
  output logic                      any,
  output logic [idx_w(WIDTH)-1:0]   idx,
  output logic [WIDTH-1:0]          clr
);

  localparam int IW = idx_w(WIDTH);

  always_comb begin
    any = |vec;
    idx = '0;
    clr = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
      end
    end
    if (any) begin
      clr[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/cover_toggle_drain.sv
// Sticky toggle-coverage collector that drains hits
// as global cover indices, one per cycle.
module cover_toggle_drain #(
  parameter int WIDTH       = 39,
  parameter int COVER_INDEX = 0,
  parameter int COVER_TOTAL = cover_pkg::COVER_TOTAL,
  parameter bit ONCE_ONLY   = 1'b1
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [WIDTH-1:0]                    valid,
  input  logic                                clear,
  cover_toggle_drain_if.master                drain,
  output logic [cover_pkg::cnt_w(WIDTH)-1:0]  covered_cnt,
  output logic [31:0]                         merged_cnt,
  output logic                                idle
);

  import cover_pkg::*;

  localparam int CW = cnt_w(WIDTH);
  localparam int IW = idx_w(WIDTH);

  if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_bad_range
    $error("cover group exceeds COVER_TOTAL");
  end

  logic [WIDTH-1:0]       pending_q, pending_d;
  logic [WIDTH-1:0]       covered_q, covered_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [31:0]            merged_q, merged_d;
  logic                   ov_q, ov_d;
  logic [COVER_IDX_W-1:0] oi_q, oi_d;

  logic                   pick_any;
  logic [IW-1:0]          pick_idx;
  logic [WIDTH-1:0]       pick_oh;

  cover_lsb_pick #(
    .WIDTH (WIDTH)
  ) u_pick (
    .vec (pending_q),
    .any (pick_any),
    .idx (pick_idx),
    .clr (pick_oh)
  );

  logic             load;
  logic [WIDTH-1:0] pick_clr;
  logic [WIDTH-1:0] cov_eff;
  logic [WIDTH-1:0] accept;
  logic             merge;

  always_comb begin
    load     = ~ov_q | drain.out_ready;
    pick_clr = load ? pick_oh : '0;
    cov_eff  = clear ? '0 : covered_q;
    accept   = valid & ~(ONCE_ONLY ? cov_eff : '0);
    // a new set beats the pick-clear of the same bit
    pending_d = (pending_q & ~pick_clr) | accept;
    covered_d = cov_eff | accept;
    merge     = |(accept & pending_q & ~pick_clr);

    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d = cnt_d + CW'(covered_d[i]);
    end

    merged_d = merged_q;
    if (merge && (merged_q != '1)) begin
      merged_d = merged_q + 32'd1;
    end

    ov_d = ov_q;
    oi_d = oi_q;
    if (load) begin
      ov_d = pick_any;
      if (pick_any) begin
        oi_d = COVER_IDX_W'(COVER_INDEX)
             + COVER_IDX_W'(pick_idx);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      covered_q <= '0;
      cnt_q     <= '0;
      merged_q  <= '0;
      ov_q      <= 1'b0;
      oi_q      <= '0;
    end else begin
      pending_q <= pending_d;
      covered_q <= covered_d;
      cnt_q     <= cnt_d;
      merged_q  <= merged_d;
      ov_q      <= ov_d;
      oi_q      <= oi_d;
    end
  end

  assign drain.out_valid = ov_q;
  assign drain.out_index = oi_q;
  assign covered_cnt     = cnt_q;
  assign merged_cnt      = merged_q;
  assign idle            = ~ov_q & ~(|pending_q);

endmodule

// File: tb/tb_cover_toggle_drain.sv
// Directed bench for cover_toggle_drain with one
// ONCE_ONLY=1 and one ONCE_ONLY=0 instance.
module tb_cover_toggle_drain;

  localparam int W  = 39;
  localparam int CI = 1000;

  logic          clock;
  logic          reset;
  logic [W-1:0]  valid1, valid0;
  logic          clear1, clear0;
  logic [5:0]    cnt1, cnt0;
  logic [31:0]   mrg1, mrg0;
  logic          idle1, idle0;

  int checks;
  int failures;

  cover_toggle_drain_if o1();
  cover_toggle_drain_if o0();

  cover_toggle_drain #(
    .WIDTH (W), .COVER_INDEX (CI),
    .COVER_TOTAL (38253), .ONCE_ONLY (1'b1)
  ) dut1 (
    .clock (clock), .reset (reset),
    .valid (valid1), .clear (clear1),
    .drain (o1), .covered_cnt (cnt1),
    .merged_cnt (mrg1), .idle (idle1)
  );

  cover_toggle_drain #(
    .WIDTH (W), .COVER_INDEX (CI),
    .COVER_TOTAL (38253), .ONCE_ONLY (1'b0)
  ) dut0 (
    .clock (clock), .reset (reset),
    .valid (valid0), .clear (clear0),
    .drain (o0), .covered_cnt (cnt0),
    .merged_cnt (mrg0), .idle (idle0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    valid1 = '0; valid0 = '0;
    clear1 = 1'b0; clear0 = 1'b0;
    o1.out_ready = 1'b1;
    o0.out_ready = 1'b1;
    cyc(); cyc();
    check("rst_ov1", 64'(o1.out_valid), 0);
    check("rst_idx1", o1.out_index, 0);
    check("rst_idle1", 64'(idle1), 1);
    check("rst_cnt1", 64'(cnt1), 0);
    check("rst_mrg1", 64'(mrg1), 0);
    check("rst_ov0", 64'(o0.out_valid), 0);
    #2 reset = 1'b1;
    cyc();

    // T1: bits 0,5,38 drain in order
    valid1[0] = 1'b1; valid1[5] = 1'b1; valid1[38] = 1'b1;
    cyc();
    valid1 = '0;
    check("t1_cnt", 64'(cnt1), 3);
    check("t1_ov_lat", 64'(o1.out_valid), 0);
    cyc();
    check("t1_ov_a", 64'(o1.out_valid), 1);
    check("t1_idx_a", o1.out_index, 1000);
    cyc();
    check("t1_ov_b", 64'(o1.out_valid), 1);
    check("t1_idx_b", o1.out_index, 1005);
    cyc();
    check("t1_ov_c", 64'(o1.out_valid), 1);
    check("t1_idx_c", o1.out_index, 1038);
    cyc();
    check("t1_ov_end", 64'(o1.out_valid), 0);
    check("t1_idle", 64'(idle1), 1);
    check("t1_cnt_end", 64'(cnt1), 3);

    // T2: re-hit of covered bit is filtered
    valid1[5] = 1'b1;
    cyc();
    valid1 = '0;
    check("t2_idle", 64'(idle1), 1);
    cyc();
    check("t2_ov", 64'(o1.out_valid), 0);
    check("t2_cnt", 64'(cnt1), 3);
    check("t2_mrg", 64'(mrg1), 0);

    // T4: clear with same-cycle hit re-reports
    clear1 = 1'b1;
    valid1[5] = 1'b1;
    cyc();
    clear1 = 1'b0;
    valid1 = '0;
    check("t4_cnt", 64'(cnt1), 1);
    cyc();
    check("t4_ov", 64'(o1.out_valid), 1);
    check("t4_idx", o1.out_index, 1005);
    cyc();
    check("t4_ov_end", 64'(o1.out_valid), 0);

    // T5: all bits, back-to-back drain
    clear1 = 1'b1;
    valid1 = '1;
    cyc();
    clear1 = 1'b0;
    valid1 = '0;
    check("t5_cnt", 64'(cnt1), 39);
    for (int i = 0; i < W; i++) begin
      cyc();
      check("t5_ov", 64'(o1.out_valid), 1);
      check("t5_idx", o1.out_index, 64'(CI + i));
    end
    cyc();
    check("t5_ov_end", 64'(o1.out_valid), 0);
    check("t5_idle", 64'(idle1), 1);

    // T3: backpressure, merge, release order
    o0.out_ready = 1'b0;
    valid0[3] = 1'b1; valid0[4] = 1'b1;
    cyc();
    valid0 = '0;
    for (int k = 0; k < 10; k++) begin
      valid0 = '0;
      if (k == 3) valid0[4] = 1'b1;
      cyc();
      check("t3_hold_ov", 64'(o0.out_valid), 1);
      check("t3_hold_idx", o0.out_index, 1003);
    end
    valid0 = '0;
    check("t3_mrg", 64'(mrg0), 1);
    check("t3_cnt", 64'(cnt0), 2);
    o0.out_ready = 1'b1;
    cyc();
    check("t3_rel_ov", 64'(o0.out_valid), 1);
    check("t3_rel_idx", o0.out_index, 1004);
    cyc();
    check("t3_end_ov", 64'(o0.out_valid), 0);
    cyc();
    check("t3_end_ov2", 64'(o0.out_valid), 0);
    check("t3_mrg_end", 64'(mrg0), 1);

    // T6: async reset mid-drain
    o1.out_ready = 1'b0;
    clear1 = 1'b1;
    for (int i = 0; i < 20; i++) valid1[i] = 1'b1;
    cyc();
    clear1 = 1'b0;
    valid1 = '0;
    cyc();
    check("t6_pre_ov", 64'(o1.out_valid), 1);
    check("t6_pre_cnt", 64'(cnt1), 20);
    #1 reset = 1'b0;
    #1;
    check("t6_async_ov", 64'(o1.out_valid), 0);
    check("t6_async_idle", 64'(idle1), 1);
    check("t6_async_cnt", 64'(cnt1), 0);
    #2 reset = 1'b1;
    o1.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      check("t6_post_ov", 64'(o1.out_valid), 0);
    end
    check("t6_post_cnt", 64'(cnt1), 0);
    check("t6_post_idle", 64'(idle1), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
